// File: rtl/wdt_if.sv
// RIB slave bus bundle for the watchdog timer: write enable, address, write data, read data.
interface wdt_if;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [31:0] data_o;

    modport master (output we_i, output addr_i, output data_i, input data_o);
    modport slave  (input we_i, input addr_i, input data_i, output data_o);
endinterface

// File: rtl/wdt.sv
// Watchdog timer: down-counter reloaded by a keyed KICK write, bites with a fixed-width reset pulse.
// Optional early-warning interrupt is built only when macro WDT_IRQ_EN is defined.
//
// state | meaning
// IDLE  | counter frozen, waiting for CTRL.EN 0->1
// RUN   | counter decrementing, waiting for kicks
// BITE  | wdt_rst_o asserted for RST_PULSE_CYCLES cycles
module wdt #(
    parameter int unsigned RST_PULSE_CYCLES = 16,
    parameter logic [31:0] KICK_KEY         = 32'h5A5A_A5A5
) (
    input  logic clk,
    input  logic rst,
    wdt_if.slave bus,
    output logic wdt_rst_o,
    output logic irq_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_BITE = 2'd2
    } state_t;

    localparam logic [7:0] PULSE_INIT = 8'(RST_PULSE_CYCLES);

    state_t      state;
    state_t      state_nxt;

    logic        en;
    logic        lock;
    logic        rst_flag;
    logic        irq_en;
    logic [31:0] load;
    logic [31:0] count;
    logic [7:0]  pulse_cnt;

    logic [3:0]  off;
    logic        wr_ctrl;
    logic        wr_load;
    logic        wr_kick;
    logic        kick_ok;
    logic        cfg_ok;
    logic        unused_addr;

    logic        count_load;
    logic        count_dec;
    logic        bite_entry;
    logic        bite_exit;

    assign off         = bus.addr_i[3:0];
    assign unused_addr = ^bus.addr_i[31:4];
    assign wr_ctrl     = bus.we_i && (off == 4'h0);
    assign wr_load     = bus.we_i && (off == 4'h4);
    assign wr_kick     = bus.we_i && (off == 4'hC);
    assign kick_ok     = (bus.data_i == KICK_KEY);
    assign cfg_ok      = (state != ST_BITE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (wr_ctrl && !lock && !en && bus.data_i[0]) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // a kick (good or bad) takes precedence over the terminal count
                if (wr_kick) begin
                    state_nxt = kick_ok ? ST_RUN : ST_BITE;
                end else if (wr_ctrl && !lock && !bus.data_i[0]) begin
                    state_nxt = ST_IDLE;
                end else if (count == 32'd0) begin
                    state_nxt = ST_BITE;
                end
            end
            ST_BITE: begin
                if (pulse_cnt == 8'd1) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        bite_entry = (state != ST_BITE) && (state_nxt == ST_BITE);
        bite_exit  = (state == ST_BITE) && (state_nxt == ST_IDLE);
        count_load = ((state == ST_IDLE) && (state_nxt == ST_RUN)) ||
                     ((state == ST_RUN) && wr_kick && kick_ok) ||
                     bite_exit;
        count_dec  = (state == ST_RUN) && (state_nxt == ST_RUN) &&
                     !count_load && (count != 32'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= 32'h0000_FFFF;
            load      <= 32'h0000_FFFF;
            pulse_cnt <= 8'd0;
            wdt_rst_o <= 1'b0;
            en        <= 1'b0;
            lock      <= 1'b0;
            rst_flag  <= 1'b0;
        end else begin
            if (count_load) begin
                count <= load;
            end else if (count_dec) begin
                count <= count - 32'd1;
            end

            if (bite_entry) begin
                pulse_cnt <= PULSE_INIT;
            end else if (state == ST_BITE) begin
                pulse_cnt <= pulse_cnt - 8'd1;
            end

            wdt_rst_o <= (state_nxt == ST_BITE);

            if (bite_exit) begin
                en <= 1'b0;
            end else if (wr_ctrl && cfg_ok && !lock) begin
                en <= bus.data_i[0];
            end

            if (wr_ctrl && cfg_ok) begin
                lock <= lock | bus.data_i[1];
            end

            // W1C clear is honoured even mid-bite; a simultaneous bite exit wins
            if (bite_exit) begin
                rst_flag <= 1'b1;
            end else if (wr_ctrl && bus.data_i[2]) begin
                rst_flag <= 1'b0;
            end

            if (wr_load && cfg_ok && !lock) begin
                load <= bus.data_i;
            end
        end
    end

`ifdef WDT_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_ctrl && cfg_ok) begin
                irq_en <= bus.data_i[3];
            end
            irq_q <= (state == ST_RUN) && irq_en && (count <= {1'b0, load[31:1]});
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_en = 1'b0;
    assign irq_o  = 1'b0;
`endif

    always_comb begin
        bus.data_o = 32'd0;
        unique case (off)
            4'h0:    bus.data_o = {28'd0, irq_en, rst_flag, lock, en};
            4'h4:    bus.data_o = load;
            4'h8:    bus.data_o = count;
            default: bus.data_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_wdt.sv
// Directed self-checking bench for the watchdog timer; irq checks follow the WDT_IRQ_EN build.
module tb_wdt;
    localparam logic [31:0] A_CTRL  = 32'h0;
    localparam logic [31:0] A_LOAD  = 32'h4;
    localparam logic [31:0] A_COUNT = 32'h8;
    localparam logic [31:0] A_KICK  = 32'hC;
    localparam logic [31:0] KEY     = 32'h5A5A_A5A5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wdt_rst_o;
    logic irq_o;
    int   errors = 0;
    int   checks = 0;

    wdt_if bus ();

    wdt #(.RST_PULSE_CYCLES(16), .KICK_KEY(KEY)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .wdt_rst_o (wdt_rst_o),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.we_i   = 1'b1;
        bus.addr_i = a;
        bus.data_i = d;
        @(negedge clk);
        bus.we_i   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        bus.addr_i = a;
        #1;
        d = bus.data_o;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        rd(A_CTRL, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=%h", d, 32'h0); end
        rd(A_LOAD, d);  checks++; if (d !== 32'hFFFF) begin errors++; $display("FAIL reset_load got=%h exp=%h", d, 32'hFFFF); end
        rd(A_COUNT, d); checks++; if (d !== 32'hFFFF) begin errors++; $display("FAIL reset_count got=%h exp=%h", d, 32'hFFFF); end
        rd(A_KICK, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_kick_read got=%h exp=0", d); end
        rd(32'h2, d);   checks++; if (d !== 32'h0) begin errors++; $display("FAIL unmapped_read got=%h exp=0", d); end
        checks++; if (wdt_rst_o !== 1'b0) begin errors++; $display("FAIL reset_wdt_rst got=%b exp=0", wdt_rst_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq_o); end
    endtask

    task automatic test_bite();
        logic [31:0] d;
        int hi;
        do_reset();
        wr(A_LOAD, 32'd10);
        wr(A_CTRL, 32'h1);
        rd(A_COUNT, d); checks++; if (d !== 32'd10) begin errors++; $display("FAIL bite_count_start got=%0d exp=10", d); end
        repeat (10) tick();
        rd(A_COUNT, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL bite_count_zero got=%0d exp=0", d); end
        checks++; if (wdt_rst_o !== 1'b0) begin errors++; $display("FAIL bite_early got=%b exp=0", wdt_rst_o); end
        tick();
        checks++; if (wdt_rst_o !== 1'b1) begin errors++; $display("FAIL bite_edge11 got=%b exp=1", wdt_rst_o); end
        hi = (wdt_rst_o === 1'b1) ? 1 : 0;
        while (wdt_rst_o === 1'b1 && hi < 40) begin
            tick();
            if (wdt_rst_o === 1'b1) hi++;
        end
        checks++; if (hi != 16) begin errors++; $display("FAIL bite_pulse_width got=%0d exp=16", hi); end
        rd(A_CTRL, d);  checks++; if (d !== 32'h4) begin errors++; $display("FAIL bite_ctrl_after got=%h exp=4", d); end
        rd(A_COUNT, d); checks++; if (d !== 32'd10) begin errors++; $display("FAIL bite_count_reload got=%0d exp=10", d); end
    endtask

    task automatic test_kick_at_zero();
        logic [31:0] d;
        do_reset();
        wr(A_LOAD, 32'd10);
        wr(A_CTRL, 32'h1);
        repeat (10) tick();
        rd(A_COUNT, d); checks++; if (d !== 32'd0) begin errors++; $display("FAIL kick0_count_zero got=%0d exp=0", d); end
        wr(A_KICK, KEY);
        rd(A_COUNT, d); checks++; if (d !== 32'd10) begin errors++; $display("FAIL kick0_reload got=%0d exp=10", d); end
        checks++; if (wdt_rst_o !== 1'b0) begin errors++; $display("FAIL kick0_no_bite got=%b exp=0", wdt_rst_o); end
        tick();
        wr(A_COUNT, 32'd123);
        rd(A_COUNT, d); checks++; if (d !== 32'd8) begin errors++; $display("FAIL count_write_ignored got=%0d exp=8", d); end
        wr(A_CTRL, 32'h0);
        repeat (2) tick();
        rd(A_COUNT, d); checks++; if (d !== 32'd8) begin errors++; $display("FAIL disable_freeze got=%0d exp=8", d); end
        rd(A_CTRL, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL disable_ctrl got=%h exp=0", d); end
    endtask

    task automatic test_bad_kick();
        logic [31:0] d;
        int n;
        do_reset();
        wr(A_LOAD, 32'd100);
        wr(A_CTRL, 32'h1);
        wr(A_KICK, 32'h1234_5678);
        checks++; if (wdt_rst_o !== 1'b1) begin errors++; $display("FAIL badkick_bite got=%b exp=1", wdt_rst_o); end
        wr(A_LOAD, 32'd7);
        rd(A_LOAD, d); checks++; if (d !== 32'd100) begin errors++; $display("FAIL bite_write_ignored got=%0d exp=100", d); end
        n = 0;
        while (wdt_rst_o === 1'b1 && n < 40) begin tick(); n++; end
        checks++; if (wdt_rst_o !== 1'b0) begin errors++; $display("FAIL badkick_pulse_end got=%b exp=0", wdt_rst_o); end
        rd(A_CTRL, d); checks++; if (d !== 32'h4) begin errors++; $display("FAIL badkick_flag got=%h exp=4", d); end
        wr(A_CTRL, 32'h4);
        rd(A_CTRL, d); checks++; if (d !== 32'h0) begin errors++; $display("FAIL flag_w1c got=%h exp=0", d); end
    endtask

    task automatic test_lock();
        logic [31:0] d;
        do_reset();
        wr(A_CTRL, 32'h3);
        wr(A_CTRL, 32'h0);
        wr(A_LOAD, 32'd5);
        rd(A_CTRL, d);  checks++; if (d !== 32'h3) begin errors++; $display("FAIL lock_ctrl got=%h exp=3", d); end
        rd(A_LOAD, d);  checks++; if (d !== 32'hFFFF) begin errors++; $display("FAIL lock_load got=%h exp=ffff", d); end
        rd(A_COUNT, d); checks++; if (d !== 32'hFFFD) begin errors++; $display("FAIL lock_count got=%h exp=fffd", d); end
        wr(A_KICK, KEY);
        rd(A_COUNT, d); checks++; if (d !== 32'hFFFF) begin errors++; $display("FAIL lock_kick got=%h exp=ffff", d); end
    endtask

    task automatic test_load_zero();
        logic [31:0] d;
        int n;
        do_reset();
        wr(A_LOAD, 32'd0);
        wr(A_CTRL, 32'h1);
        checks++; if (wdt_rst_o !== 1'b0) begin errors++; $display("FAIL load0_enable got=%b exp=0", wdt_rst_o); end
        tick();
        checks++; if (wdt_rst_o !== 1'b1) begin errors++; $display("FAIL load0_bite got=%b exp=1", wdt_rst_o); end
        n = 0;
        while (wdt_rst_o === 1'b1 && n < 40) begin tick(); n++; end
        rd(A_CTRL, d); checks++; if (d !== 32'h4) begin errors++; $display("FAIL load0_ctrl got=%h exp=4", d); end
    endtask

    // relies on RST_FLAG left set by test_load_zero
    task automatic test_rst_mid_bite();
        logic [31:0] d;
        int n;
        wr(A_LOAD, 32'd2);
        wr(A_CTRL, 32'h1);
        n = 0;
        while (wdt_rst_o !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (wdt_rst_o !== 1'b1) begin errors++; $display("FAIL midbite_start got=%b exp=1", wdt_rst_o); end
        repeat (2) tick();
        rst = 1'b1;
        tick();
        checks++; if (wdt_rst_o !== 1'b0) begin errors++; $display("FAIL midbite_rst got=%b exp=0", wdt_rst_o); end
        rd(A_CTRL, d);  checks++; if (d !== 32'h0) begin errors++; $display("FAIL midbite_ctrl got=%h exp=0", d); end
        rd(A_LOAD, d);  checks++; if (d !== 32'hFFFF) begin errors++; $display("FAIL midbite_load got=%h exp=ffff", d); end
        rd(A_COUNT, d); checks++; if (d !== 32'hFFFF) begin errors++; $display("FAIL midbite_count got=%h exp=ffff", d); end
        rst = 1'b0;
        tick();
        checks++; if (wdt_rst_o !== 1'b0) begin errors++; $display("FAIL midbite_after got=%b exp=0", wdt_rst_o); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        int seen;
        do_reset();
        wr(A_LOAD, 32'd20);
        wr(A_CTRL, 32'h9);
`ifdef WDT_IRQ_EN
        rd(A_CTRL, d); checks++; if (d !== 32'h9) begin errors++; $display("FAIL irq_ctrl got=%h exp=9", d); end
        repeat (10) tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_early got=%b exp=0", irq_o); end
        tick();
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_rise got=%b exp=1", irq_o); end
        wr(A_KICK, KEY);
        checks++; if (irq_o !== 1'b1) begin errors++; $display("FAIL irq_kick_edge got=%b exp=1", irq_o); end
        tick();
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL irq_clear got=%b exp=0", irq_o); end
        seen = 0;
`else
        rd(A_CTRL, d); checks++; if (d !== 32'h1) begin errors++; $display("FAIL irq_en_ignored got=%h exp=1", d); end
        seen = 0;
        repeat (30) begin
            tick();
            if (irq_o !== 1'b0) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL irq_stuck_zero got=%0d exp=0 cycles high", seen); end
`endif
    endtask

    initial begin
        bus.we_i   = 1'b0;
        bus.addr_i = 32'h0;
        bus.data_i = 32'h0;
        test_reset();
        test_bite();
        test_kick_at_zero();
        test_bad_kick();
        test_lock();
        test_load_zero();
        test_rst_mid_bite();
        test_irq();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
